// File: rtl/tri_span_sched.sv
// tri_span_sched: scanline scheduler for the interp_tri array.
// Walks lines y_first..y_last and emits one span per matching unit per line.
module tri_span_sched #(
    parameter int N_TRI = 64,
    parameter int CB    = 8,
    localparam int IW   = (N_TRI > 1) ? $clog2(N_TRI) : 1
) (
    input  logic                built_in_unused_guard_n = 1'b1,
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                frame_start_i,
    input  logic [CB-1:0]       y_first_i,
    input  logic [CB-1:0]       y_last_i,
    input  logic [N_TRI-1:0]    tri_en_i,
    input  logic [N_TRI*CB-1:0] tri_y_i,
    input  logic [N_TRI*CB-1:0] tri_x_start_i,
    input  logic [N_TRI*CB-1:0] tri_x_end_i,
    output logic [N_TRI-1:0]    tri_step_o,
    output logic                span_valid_o,
    input  logic                span_ready_i,
    output logic [CB-1:0]       span_y_o,
    output logic [CB-1:0]       span_x0_o,
    output logic [CB-1:0]       span_x1_o,
    output logic [IW-1:0]       span_id_o,
    output logic                line_done_o,
    output logic                frame_done_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        LINE_END
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CB-1:0]    cur_y;
    logic [CB-1:0]    y_end;
    logic [N_TRI-1:0] served;
    logic [N_TRI-1:0] pend;
    logic [N_TRI-1:0] step_q;
    logic             pick_ok;
    logic [IW-1:0]    pick_id;
    logic [CB-1:0]    pick_x0;
    logic [CB-1:0]    pick_x1;
    logic             degen;
    logic             last_line;
    logic             hs;

    // Pending mask and lowest-index pick among unserved matching units
    always_comb begin
        pend    = '0;
        pick_ok = 1'b0;
        pick_id = '0;
        pick_x0 = '0;
        pick_x1 = '0;
        for (int i = 0; i < N_TRI; i++) begin
            pend[i] = tri_en_i[i] && !served[i] &&
                      (tri_y_i[i*CB +: CB] == cur_y);
        end
        for (int i = N_TRI - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick_ok = 1'b1;
                pick_id = IW'(i);
                pick_x0 = tri_x_start_i[i*CB +: CB];
                pick_x1 = tri_x_end_i[i*CB +: CB];
            end
        end
    end

    assign degen     = pick_x0 > pick_x1;
    assign last_line = cur_y == y_end;
    assign hs        = span_valid_o && span_ready_i;
    assign busy_o    = state != IDLE;

    // Step strobe: handshake cycle for emitted spans, next cycle for degenerate
    assign tri_step_o = step_q |
        ({N_TRI{hs}} & (N_TRI'(1) << span_id_o));

    // State register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (frame_start_i) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (!pick_ok) begin
                    state_nx = LINE_END;
                end else if (!degen) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (span_ready_i) begin
                    state_nx = SCAN;
                end
            end
            LINE_END: begin
                state_nx = last_line ? IDLE : SCAN;
            end
        endcase
    end

    // Line counter, served mask, span registers and strobes
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_y        <= '0;
            y_end        <= '0;
            served       <= '0;
            step_q       <= '0;
            span_valid_o <= 1'b0;
            span_y_o     <= '0;
            span_x0_o    <= '0;
            span_x1_o    <= '0;
            span_id_o    <= '0;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            step_q       <= '0;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        cur_y  <= y_first_i;
                        y_end  <= y_last_i;
                        served <= '0;
                    end
                end
                SCAN: begin
                    if (pick_ok) begin
                        span_y_o        <= cur_y;
                        span_x0_o       <= pick_x0;
                        span_x1_o       <= pick_x1;
                        span_id_o       <= pick_id;
                        served[pick_id] <= 1'b1;
                        span_valid_o    <= !degen;
                        if (degen) begin
                            step_q <= N_TRI'(1) << pick_id;
                        end
                    end else begin
                        line_done_o  <= 1'b1;
                        frame_done_o <= last_line;
                    end
                end
                EMIT: begin
                    if (span_ready_i) begin
                        span_valid_o <= 1'b0;
                    end
                end
                LINE_END: begin
                    served <= '0;
                    if (!last_line) begin
                        cur_y <= cur_y + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_span_sched.sv
// tb_tri_span_sched: directed and randomized checks of tri_span_sched.
// A line-by-line model of the unit array predicts spans and step counts.
module tb_tri_span_sched;

    localparam int N  = 64;
    localparam int CB = 8;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            frame_start_i = 1'b0;
    logic [CB-1:0]   y_first_i = '0;
    logic [CB-1:0]   y_last_i = '0;
    logic [N-1:0]    tri_en_i = '0;
    logic [N*CB-1:0] tri_y_i = '0;
    logic [N*CB-1:0] tri_x_start_i = '0;
    logic [N*CB-1:0] tri_x_end_i = '0;
    logic [N-1:0]    tri_step_o;
    logic            span_valid_o;
    logic            span_ready_i = 1'b0;
    logic [CB-1:0]   span_y_o;
    logic [CB-1:0]   span_x0_o;
    logic [CB-1:0]   span_x1_o;
    logic [5:0]      span_id_o;
    logic            line_done_o;
    logic            frame_done_o;
    logic            busy_o;

    always #5 clk = ~clk;

    tri_span_sched #(.N_TRI(N), .CB(CB)) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .frame_start_i(frame_start_i),
        .y_first_i    (y_first_i),
        .y_last_i     (y_last_i),
        .tri_en_i     (tri_en_i),
        .tri_y_i      (tri_y_i),
        .tri_x_start_i(tri_x_start_i),
        .tri_x_end_i  (tri_x_end_i),
        .tri_step_o   (tri_step_o),
        .span_valid_o (span_valid_o),
        .span_ready_i (span_ready_i),
        .span_y_o     (span_y_o),
        .span_x0_o    (span_x0_o),
        .span_x1_o    (span_x1_o),
        .span_id_o    (span_id_o),
        .line_done_o  (line_done_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        int y;
        int x0;
        int x1;
        int id;
    } span_t;

    span_t expq[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  y_u[N];
    int  xs_u[N];
    int  xe_u[N];
    int  ystop[N];
    int  dly[N];
    int  cnt[N];
    int  expy[N];
    bit  ben[N];
    bit  upd[N];
    bit  use_fn;
    int  rdy_mode;
    int  hold_n;
    int  stalls;
    int  lines_seen;
    int  frames_seen;
    int  valid_cycles;
    int  cyc_no;
    int  fd_cyc;
    bit  prev_stall;
    logic [CB-1:0] py;
    logic [CB-1:0] px0;
    logic [CB-1:0] px1;
    logic [5:0]    pid;

    function automatic int fx0(int i, int y);
        return (i * 37 + y * 11) % 256;
    endfunction

    function automatic int fx1(int i, int y);
        return (i * 53 + y * 29 + 40) % 256;
    endfunction

    function automatic int ux0(int i, int y);
        return use_fn ? fx0(i, y) : xs_u[i];
    endfunction

    function automatic int ux1(int i, int y);
        return use_fn ? fx1(i, y) : xe_u[i];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            tri_y_i[i*CB +: CB]       = CB'(y_u[i]);
            tri_x_start_i[i*CB +: CB] = CB'(ux0(i, y_u[i]));
            tri_x_end_i[i*CB +: CB]   = CB'(ux1(i, y_u[i]));
            tri_en_i[i] = ben[i] && (y_u[i] <= ystop[i]);
        end
    endtask

    task automatic clear_units();
        use_fn = 1'b0;
        for (int i = 0; i < N; i++) begin
            ben[i]   = 1'b0;
            y_u[i]   = 0;
            xs_u[i]  = 0;
            xe_u[i]  = 0;
            ystop[i] = 255;
            dly[i]   = 0;
            cnt[i]   = 0;
            upd[i]   = 1'b0;
        end
        expq.delete();
        drive();
    endtask

    task automatic model(int yf, int yl);
        int ym[N];
        for (int i = 0; i < N; i++) ym[i] = y_u[i];
        for (int l = yf; l <= yl; l++) begin
            for (int i = 0; i < N; i++) begin
                if (ben[i] && ym[i] <= ystop[i] && ym[i] == l) begin
                    if (ux0(i, l) <= ux1(i, l))
                        expq.push_back('{l, ux0(i, l), ux1(i, l), i});
                    ym[i]++;
                end
            end
        end
        for (int i = 0; i < N; i++) expy[i] = ym[i];
    endtask

    task automatic cyc();
        span_t e;
        logic [63:0] oh;
        @(posedge clk);
        #1;
        cyc_no++;
        for (int i = 0; i < N; i++) begin
            if (upd[i]) begin
                if (cnt[i] == 0) begin
                    y_u[i]++;
                    upd[i] = 1'b0;
                end else begin
                    cnt[i]--;
                end
            end
        end
        drive();
        case (rdy_mode)
            0: span_ready_i = 1'b1;
            1: span_ready_i = $urandom_range(0, 3) != 0;
            default: span_ready_i = !(span_valid_o && stalls < hold_n);
        endcase
        #1;
        if (span_valid_o) begin
            valid_cycles++;
            if (prev_stall) begin
                chk("hold_y", span_y_o, py);
                chk("hold_x0", span_x0_o, px0);
                chk("hold_x1", span_x1_o, px1);
                chk("hold_id", span_id_o, pid);
            end
            if (span_ready_i) begin
                prev_stall = 1'b0;
                chk("span_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    oh = 64'd1 << e.id;
                    chk("span_y", span_y_o, e.y);
                    chk("span_x0", span_x0_o, e.x0);
                    chk("span_x1", span_x1_o, e.x1);
                    chk("span_id", span_id_o, e.id);
                    chk("step_hs", tri_step_o, oh);
                end
            end else begin
                stalls++;
                chk("step_stall", tri_step_o, 0);
                prev_stall = 1'b1;
                py  = span_y_o;
                px0 = span_x0_o;
                px1 = span_x1_o;
                pid = span_id_o;
            end
        end else begin
            prev_stall = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (tri_step_o[i]) begin
                upd[i] = 1'b1;
                cnt[i] = dly[i];
            end
        end
        if (line_done_o) lines_seen++;
        if (frame_done_o) begin
            frames_seen++;
            fd_cyc = cyc_no;
        end
    endtask

    task automatic reset_counts();
        lines_seen   = 0;
        frames_seen  = 0;
        valid_cycles = 0;
        cyc_no       = 0;
        fd_cyc       = 0;
        stalls       = 0;
        prev_stall   = 1'b0;
    endtask

    task automatic run_frame(int yf, int yl, int exp_lines, int budget);
        y_first_i = CB'(yf);
        y_last_i  = CB'(yl);
        reset_counts();
        frame_start_i = 1'b1;
        cyc();
        frame_start_i = 1'b0;
        chk("busy_start", busy_o, 1);
        while (frames_seen == 0 && cyc_no < budget) cyc();
        chk("frame_done", frames_seen, 1);
        chk("line_done_cnt", lines_seen, exp_lines);
        chk("spans_left", expq.size(), 0);
        cyc();
        chk("busy_end", busy_o, 0);
        chk("frame_done_once", frames_seen, 1);
    endtask

    task automatic settle_and_check_steps(string tag);
        for (int k = 0; k < 6; k++) cyc();
        for (int i = 0; i < N; i++) chk(tag, y_u[i], expy[i]);
    endtask

    initial begin
        rdy_mode = 0;
        hold_n   = 0;
        reset_counts();
        clear_units();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", span_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_step", tri_step_o, 0);
        chk("rst_line", line_done_o, 0);
        chk("rst_frame", frame_done_o, 0);
        chk("rst_fields", {span_y_o, span_x0_o, span_x1_o, span_id_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        cyc();

        // three units on one line, ready high
        clear_units();
        ben[0] = 1; y_u[0] = 10; xs_u[0] = 3;   xe_u[0] = 17;
        ben[5] = 1; y_u[5] = 10; xs_u[5] = 100; xe_u[5] = 140;
        ben[63] = 1; y_u[63] = 10; xs_u[63] = 7; xe_u[63] = 7;
        drive();
        model(10, 10);
        rdy_mode = 0;
        run_frame(10, 10, 1, 200);
        chk("three_fd_cycle", fd_cyc, 8);
        settle_and_check_steps("three_step_y");

        // backpressure on the first span
        clear_units();
        ben[0] = 1; y_u[0] = 10; xs_u[0] = 1; xe_u[0] = 2;
        ben[5] = 1; y_u[5] = 10; xs_u[5] = 9; xe_u[5] = 90;
        drive();
        model(10, 10);
        rdy_mode = 2;
        hold_n = 5;
        run_frame(10, 10, 1, 200);
        chk("bp_stalls", stalls, 5);
        settle_and_check_steps("bp_step_y");

        // slow y update
        clear_units();
        ben[3] = 1; y_u[3] = 10; xs_u[3] = 4; xe_u[3] = 44; dly[3] = 4;
        drive();
        model(10, 10);
        rdy_mode = 0;
        run_frame(10, 10, 1, 200);
        chk("slow_spans", valid_cycles, 1);
        settle_and_check_steps("slow_step_y");

        // degenerate span alongside a normal one
        clear_units();
        ben[7] = 1; y_u[7] = 10; xs_u[7] = 20; xe_u[7] = 5;
        ben[9] = 1; y_u[9] = 10; xs_u[9] = 30; xe_u[9] = 60;
        drive();
        model(10, 10);
        run_frame(10, 10, 1, 200);
        chk("degen_spans", valid_cycles, 1);
        settle_and_check_steps("degen_step_y");

        // wrapping multi-line empty frame
        clear_units();
        run_frame(254, 1, 4, 200);
        chk("wrap_fd_cycle", fd_cyc, 8);
        chk("wrap_spans", valid_cycles, 0);

        // randomized multi-line frames
        for (int f = 0; f < 3; f++) begin
            clear_units();
            use_fn = 1'b1;
            for (int i = 0; i < N; i++) begin
                ben[i]   = $urandom_range(0, 3) == 0;
                y_u[i]   = $urandom_range(18, 40);
                ystop[i] = y_u[i] + $urandom_range(0, 5);
            end
            drive();
            model(20, 45);
            rdy_mode = 1;
            run_frame(20, 45, 26, 4000);
            settle_and_check_steps("rand_step_y");
        end

        // reset in EMIT, with a start issued while busy
        clear_units();
        ben[2] = 1; y_u[2] = 10; xs_u[2] = 11; xe_u[2] = 22;
        drive();
        rdy_mode = 2;
        hold_n = 1000;
        reset_counts();
        y_first_i = 8'd10;
        y_last_i  = 8'd10;
        frame_start_i = 1'b1;
        cyc();
        frame_start_i = 1'b0;
        cyc();
        chk("emit_valid", span_valid_o, 1);
        y_first_i = 8'd50;
        y_last_i  = 8'd60;
        frame_start_i = 1'b1;
        cyc();
        frame_start_i = 1'b0;
        cyc();
        chk("ign_start_y", span_y_o, 10);
        chk("ign_start_busy", busy_o, 1);
        chk("ign_start_valid", span_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", span_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_step", tri_step_o, 0);
        chk("arst_strobes", {line_done_o, frame_done_o}, 0);
        chk("arst_fields", {span_y_o, span_x0_o, span_x1_o, span_id_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        rdy_mode = 0;
        reset_counts();
        cyc();
        cyc();
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_frame", frames_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tri_span_sched.md
# tri_span_sched

Scanline scheduler for the triangle interpolator array. Walks the frame one scanline at a time on the GPU clock. For each line it finds every interpolator whose current `y` matches the line and emits that unit's `[x_start, x_end]` span to the pixel pipeline over a valid/ready handshake. It then pulses the unit's step strobe so the unit advances to its next scanline. It sits between the 64 `interp_tri` instances and the downstream span consumer.

## Interface
- `N_TRI`, default 64, number of interpolator units scheduled.
- `CB`, default 8, coordinate width (y, x).
- `clk`  in  1  GPU clock (`user_clock2` domain); all logic on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `frame_start_i`  in  1  single-cycle pulse that starts a frame; ignored unless idle.
- `y_first_i`  in  CB  first scanline of the frame; sampled on accepted `frame_start_i`.
- `y_last_i`  in  CB  last scanline, inclusive; sampled on accepted `frame_start_i`.
- `tri_en_i`  in  N_TRI  per-unit enable; only enabled units are scheduled.
- `tri_y_i`  in  N_TRI*CB  packed current scanline of each unit; unit i is at [(i+1)*CB-1 : i*CB].
- `tri_x_start_i`  in  N_TRI*CB  packed span start, same packing.
- `tri_x_end_i`  in  N_TRI*CB  packed span end, same packing.
- `tri_step_o`  out  N_TRI  one-cycle pulse: unit i advances to its next scanline.
- `span_valid_o`  out  1  span available.
- `span_ready_i`  in  1  consumer accepts the span when high together with `span_valid_o`.
- `span_y_o`  out  CB  scanline of the span.
- `span_x0_o`  out  CB  span start.
- `span_x1_o`  out  CB  span end.
- `span_id_o`  out  6  source unit index (log2 of N_TRI).
- `line_done_o`  out  1  one-cycle pulse when a scanline finishes.
- `frame_done_o`  out  1  one-cycle pulse when the last scanline finishes.
- `busy_o`  out  1  high whenever not IDLE.

## Operation
- The FSM has four states: IDLE, SCAN, EMIT, LINE_END.
- IDLE: on `frame_start_i`, load `cur_y` from `y_first_i` and `y_end` from `y_last_i`, clear the `served` mask, go to SCAN.
- SCAN: compute `pend = tri_en_i & match & ~served`, where `match[i] = (tri_y_i[i] == cur_y)`.
  - If `pend` is nonzero, take the lowest set index k. Register `cur_y` and unit k's x_start/x_end into the span outputs, set `span_id_o = k`, set `served[k]`, go to EMIT.
  - If `pend` is zero, go to LINE_END.
- EMIT: hold `span_valid_o` high with all span fields stable until `span_ready_i`.
  - On handshake, pulse `tri_step_o[k]` in the same cycle, drop valid, return to SCAN.
- Degenerate span (x_start > x_end): the SCAN pick still happens and `served[k]` is set, but no span is emitted (`span_valid_o` stays low). Pulse `tri_step_o[k]` on the next cycle, then return to SCAN.
- LINE_END (one cycle): pulse `line_done_o` and clear `served`.
  - If `cur_y == y_end`: pulse `frame_done_o`, go to IDLE.
  - Otherwise: `cur_y <= cur_y + 1` (CB-bit), go to SCAN.
- `y_first_i > y_last_i`: `cur_y` wraps modulo 2^CB until it equals `y_end`. No special casing.
- The `served` mask guarantees at most one span per unit per line, independent of how many cycles a unit takes to update `tri_y_i` after a step.
- Changes to `tri_en_i` mid-line take effect at the next SCAN evaluation.
- `frame_start_i` while busy is dropped and has no effect.

## Timing
- Reset values (async, on `rst_ni` low):
  - state IDLE;
  - `span_valid_o`, `tri_step_o`, `line_done_o`, `frame_done_o`, `busy_o` all 0;
  - `span_y_o`, `span_x0_o`, `span_x1_o`, `span_id_o`, `cur_y`, `served` all 0.
- `busy_o` goes high the cycle after the accepted `frame_start_i`.
- Latency from entering SCAN with a pending unit to `span_valid_o` is 1 cycle.
- With `span_ready_i` held high, throughput is one span per 2 cycles (SCAN, EMIT).
- An empty line costs 2 cycles (SCAN, LINE_END).
- Once valid is raised it never drops without a handshake. Span fields are frozen while valid is high and ready is low.
- Reset asserted mid-frame aborts immediately. No `frame_done_o` is produced. Any partially asserted step pulse is cleared.
- All strobe outputs are registered, single-cycle pulses.

## Test plan
- **Three units on one line.** Enable units 0, 5 and 63 with y=10, a frame with y_first=y_last=10, ready tied high.
  - Required: spans emitted in id order 0, 5, 63, each with its x values.
  - Each unit gets exactly one `tri_step_o` pulse.
  - One `line_done_o`, then `frame_done_o`, then `busy_o`=0.
- **Backpressure.** Hold `span_ready_i` low for 5 cycles on the first span.
  - Required: valid and fields stay stable for all 5 cycles.
  - `tri_step_o` pulses only in the handshake cycle.
- **Slow y update.** A unit keeps reporting y=cur_y for 4 cycles after its step.
  - Required: no second span for that unit on that line.
- **Degenerate span.** A unit has x_start=20, x_end=5.
  - Required: no span emitted, the unit is still stepped, the line completes.
- **Multi-line frame with wrap.** y_first=254, y_last=1, no units enabled.
  - Required: four `line_done_o` pulses (lines 254, 255, 0, 1), then `frame_done_o`.
  - Per-line cost is 2 cycles.
- **Reset and ignored start.** Drop `rst_ni` while in EMIT.
  - Required: all outputs return to 0 at once, then IDLE.
  - A `frame_start_i` issued while `busy_o`=1 is ignored.
